// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Parametrised pipeline register placed between stages of the 5-stage MIPS
// core (IF/ID, ID/EX, EX/MEM, MEM/WB). It moves a control bundle and a data
// bundle through DEPTH register slices, and each slice has its own valid bit.
// The hazard unit drives stall (hold every slice) and flush (turn every slice
// into a NOP bubble). Two saturating counters record bubbles and stalls.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   stall       in   1       hold every slice unchanged this cycle
//   flush       in   1       kill every slice this cycle (takes priority over stall)
//   valid_in    in   1       upstream entry is a real instruction
//   ctrl_in     in   CTRL_W  control bundle from upstream stage
//   data_in     in   DATA_W  data bundle from upstream stage
//   valid_out   out  1       valid bit of last slice
//   ctrl_out    out  CTRL_W  control bundle of last slice
//   data_out    out  DATA_W  data bundle of last slice
//   bubble_cnt  out  CNT_W   invalid entries loaded into slice 0 (saturating)
//   stall_cnt   out  CNT_W   stall cycles not overridden by flush (saturating)

module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 143,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  logic [CNT_W-1:0]  bubble_q;
  logic [CNT_W-1:0]  bubble_d;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;

  logic              hold;
  logic              advance;
  logic              loadBubble;

  // Flush overrides stall. A held cycle is a stall that no flush overrides.
  assign hold       = stall & ~flush;
  assign advance    = ~stall & ~flush;
  // Slice 0 receives an invalid entry when it is flushed or when it advances with an empty input.
  assign loadBubble = flush | (advance & ~valid_in);

  // Next state of the slices. Control is zeroed whenever valid is zero, so a
  // dead slice can never cause RegWrite/MemWrite/Branch side effects. Data is
  // left alone on flush because it is harmless without control.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      ctrl_d[k]  = ctrl_q[k];
      data_d[k]  = data_q[k];
    end

    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end
    end else if (advance) begin
      valid_d[0] = valid_in;
      ctrl_d[0]  = valid_in ? ctrl_in : '0;
      data_d[0]  = data_in;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // The performance counters stop at all-ones and do not wrap.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (loadBubble && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
    if (hold && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= '0;
        data_q[k]  <= '0;
      end
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        ctrl_q[k]  <= ctrl_d[k];
        data_q[k]  <= data_d[k];
      end
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

  assign valid_out  = valid_q[DEPTH-1];
  assign ctrl_out   = ctrl_q[DEPTH-1];
  assign data_out   = data_q[DEPTH-1];
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

endmodule
